// File: rtl/iob_mem_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : iob_mem_responder_pkg                                        |
// | Description : Shared types and constants for the IOb memory responder:    |
// |               FSM state encoding, wait-counter width and the data         |
// |               pattern returned for out-of-range reads.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package iob_mem_responder_pkg;

  // Width of the wait-state down-counter (WAIT_CYCLES up to 15).
  localparam int unsigned c_WCNT_W = 4;

  // Every bit of an out-of-range read returns this value.
  localparam logic c_OOR_RDATA_BIT = 1'b0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/iob_mem_responder_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : iob_mem_responder_ram                                        |
// | Description : DEPTH x DATA_W single-port synchronous RAM with per-byte    |
// |               write enables and a registered read port. The read register |
// |               only loads on a read strobe, so it holds the last read word. |
// | Ports       : clk_i, arst_n_i   clock / async active-low reset (read reg) |
// |               we_i              per-byte write enables                    |
// |               re_i              read strobe (loads read register)         |
// |               rd_zero_i         load the out-of-range pattern instead     |
// |               addr_i, wdata_i   word address / write data                 |
// |               rdata_o           registered read data                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module iob_mem_responder_ram
  import iob_mem_responder_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = 10
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic [DATA_W/8-1:0] we_i,
  input  logic                re_i,
  input  logic                rd_zero_i,
  input  logic [AW-1:0]       addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]   rdata_o
);

  localparam int c_STRB_W = DATA_W / 8;

  // Storage is deliberately not reset: contents survive a bus reset.
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < c_STRB_W; b++) begin
      if (we_i[b]) begin
        r_mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_rdata <= '0;
    end else if (re_i) begin
      r_rdata <= rd_zero_i ? {DATA_W{c_OOR_RDATA_BIT}} : r_mem[addr_i];
    end
  end

  assign rdata_o = r_rdata;

endmodule
`default_nettype wire

// File: rtl/iob_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : iob_mem_responder                                            |
// | Description : IOb native-bus responder serving requests from an internal  |
// |               byte-writable word memory with WAIT_CYCLES wait states per  |
// |               access. Writes complete on acceptance; each read returns    |
// |               exactly one rvalid pulse.                                    |
// | Ports       : clk_i, arst_n_i, cke_i   clock, async reset, clock enable   |
// |               iob_avalid_i/addr/wdata/wstrb   request (wstrb==0 is read)  |
// |               iob_ready_o, iob_rvalid_o, iob_rdata_o   handshake/response |
// |               err_o                     sticky out-of-range flag          |
// | Options     : IOB_MEM_RESPONDER_BOUNDS_EN - when defined, word indices    |
// |               >= DEPTH read as zero, drop writes and set err_o. When      |
// |               undefined, the index is truncated (aliases), err_o is 0.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module iob_mem_responder
  import iob_mem_responder_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                iob_avalid_i,
  input  logic [ADDR_W-1:0]   iob_addr_i,
  input  logic [DATA_W-1:0]   iob_wdata_i,
  input  logic [DATA_W/8-1:0] iob_wstrb_i,
  output logic                iob_ready_o,
  output logic                iob_rvalid_o,
  output logic [DATA_W-1:0]   iob_rdata_o,
  output logic                err_o
);

  localparam int c_IDX_W  = ADDR_W - 2;
  localparam int c_RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_WCNT_W-1:0] c_WAIT_LD =
    (WAIT_CYCLES > 0) ? c_WCNT_W'(WAIT_CYCLES - 1) : '0;

  state_t              r_state, w_state_nxt;
  logic [c_WCNT_W-1:0] r_cnt, w_cnt_nxt;
  logic                r_ready, w_ready_nxt;
  logic                r_rvalid, w_rvalid_nxt;
  logic                r_rd_pend, w_rd_pend_nxt;

  logic                w_accept;
  logic                w_is_read;
  logic                w_oor;
  logic [c_IDX_W-1:0]  w_idx;
  logic [c_RAM_AW-1:0] w_ram_addr;
  logic [DATA_W/8-1:0] w_ram_we;
  logic                w_ram_re;
  logic                w_unused;

  // cke_i is folded in so a frozen cycle can never commit a write or read.
  assign w_accept   = iob_avalid_i & r_ready & cke_i;
  assign w_is_read  = ~|iob_wstrb_i;
  assign w_idx      = iob_addr_i[ADDR_W-1:2];
  assign w_ram_addr = w_idx[c_RAM_AW-1:0];
  assign w_unused   = ^{iob_addr_i[1:0], w_idx};

`ifdef IOB_MEM_RESPONDER_BOUNDS_EN
  // One extra bit so DEPTH == 2**c_IDX_W compares correctly.
  localparam logic [c_IDX_W:0] c_DEPTH_EXT = (c_IDX_W + 1)'(DEPTH);
  logic r_err;

  assign w_oor = ({1'b0, w_idx} >= c_DEPTH_EXT);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_err <= 1'b0;
    end else if (w_accept && w_oor) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign w_oor = 1'b0;
  assign err_o = 1'b0;
`endif

  assign w_ram_we = (w_accept && !w_oor) ? iob_wstrb_i : '0;
  assign w_ram_re = w_accept & w_is_read;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_ready_nxt   = r_ready;
    w_rvalid_nxt  = 1'b0;
    w_rd_pend_nxt = r_rd_pend;
    case (r_state)
      ST_IDLE: begin
        // Also raises ready on the first enabled edge after reset.
        w_ready_nxt = 1'b1;
        if (w_accept) begin
          if (WAIT_CYCLES > 0) begin
            w_state_nxt   = ST_WAIT;
            w_cnt_nxt     = c_WAIT_LD;
            w_ready_nxt   = 1'b0;
            w_rd_pend_nxt = w_is_read;
          end else begin
            w_rvalid_nxt = w_is_read;
          end
        end
      end
      ST_WAIT: begin
        w_ready_nxt = 1'b0;
        if (r_cnt == '0) begin
          // ready and rvalid return in the same cycle.
          w_state_nxt   = ST_IDLE;
          w_ready_nxt   = 1'b1;
          w_rvalid_nxt  = r_rd_pend;
          w_rd_pend_nxt = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - c_WCNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_ready   <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rd_pend <= 1'b0;
    end else if (cke_i) begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ready   <= w_ready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rd_pend <= w_rd_pend_nxt;
    end
  end

  iob_mem_responder_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (c_RAM_AW)
  ) u_ram (
    .clk_i     (clk_i),
    .arst_n_i  (arst_n_i),
    .we_i      (w_ram_we),
    .re_i      (w_ram_re),
    .rd_zero_i (w_oor),
    .addr_i    (w_ram_addr),
    .wdata_i   (iob_wdata_i),
    .rdata_o   (iob_rdata_o)
  );

  assign iob_ready_o  = r_ready;
  assign iob_rvalid_o = r_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_iob_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_iob_mem_responder                                         |
// | Description : Self-checking bench. Instance 0 (WAIT_CYCLES=0, DEPTH=1000) |
// |               runs a vector table through a read scoreboard; instances   |
// |               1 (WAIT_CYCLES=3) and 2 (WAIT_CYCLES=2) cover wait-state   |
// |               timing, reset mid-access and clock-enable stalls.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_iob_mem_responder;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int SW = DW / 8;
  localparam int NI = 3;
  localparam int NV = 10;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [DW-1:0] exp;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          arst_n;
  logic          cke    [NI];
  logic          avalid [NI];
  logic [AW-1:0] addr   [NI];
  logic [DW-1:0] wdata  [NI];
  logic [SW-1:0] wstrb  [NI];
  logic          ready  [NI];
  logic          rvalid [NI];
  logic [DW-1:0] rdata  [NI];
  logic          err    [NI];

  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;
  int  rv_cnt [NI] = '{default: 0};
  sb_t sb_q   [$];

  iob_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(1000), .WAIT_CYCLES(0)) u_w0 (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke[0]), .iob_avalid_i(avalid[0]),
    .iob_addr_i(addr[0]), .iob_wdata_i(wdata[0]), .iob_wstrb_i(wstrb[0]),
    .iob_ready_o(ready[0]), .iob_rvalid_o(rvalid[0]), .iob_rdata_o(rdata[0]), .err_o(err[0]));

  iob_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(1024), .WAIT_CYCLES(3)) u_w3 (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke[1]), .iob_avalid_i(avalid[1]),
    .iob_addr_i(addr[1]), .iob_wdata_i(wdata[1]), .iob_wstrb_i(wstrb[1]),
    .iob_ready_o(ready[1]), .iob_rvalid_o(rvalid[1]), .iob_rdata_o(rdata[1]), .err_o(err[1]));

  iob_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(1024), .WAIT_CYCLES(2)) u_w2 (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke[2]), .iob_avalid_i(avalid[2]),
    .iob_addr_i(addr[2]), .iob_wdata_i(wdata[2]), .iob_wstrb_i(wstrb[2]),
    .iob_ready_o(ready[2]), .iob_rvalid_o(rvalid[2]), .iob_rdata_o(rdata[2]), .err_o(err[2]));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s);
    avalid[k] = 1'b1;
    addr[k]   = a;
    wdata[k]  = d;
    wstrb[k]  = s;
  endtask

  task automatic wait_ready(input int k);
    int n = 0;
    while (ready[k] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("wait_ready", 32'(ready[k]), 32'd1);
  endtask

  // Scoreboard for instance 0: every rvalid pops one expected word and due cycle.
  always @(negedge clk) begin
    sb_t e;
    for (int k = 0; k < NI; k++) begin
      if (rvalid[k] === 1'b1) rv_cnt[k]++;
    end
    if (rvalid[0] === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_spurious_rvalid", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        check("sb_rdata", rdata[0], e.data);
        check("sb_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks %0d errors %0d)", checks, errors);
    $fatal(1);
  end

  initial begin
    vec_t tv [NV];
    int   n0;

    tv[0] = '{1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 32'h0};
    tv[1] = '{1'b0, 12'h010, 32'h0,        4'h0, 32'hDEADBEEF};
    tv[2] = '{1'b1, 12'h020, 32'h11223344, 4'hF, 32'h0};
    tv[3] = '{1'b1, 12'h020, 32'hAABBCCDD, 4'h5, 32'h0};
    tv[4] = '{1'b0, 12'h020, 32'h0,        4'h0, 32'h11BB33DD};
    tv[5] = '{1'b1, 12'h024, 32'hCAFEF00D, 4'hF, 32'h0};
    tv[6] = '{1'b1, 12'h024, 32'h12345678, 4'hC, 32'h0};
    tv[7] = '{1'b0, 12'h024, 32'h0,        4'h0, 32'h1234F00D};
    tv[8] = '{1'b1, 12'hF9C, 32'h0F0F0F0F, 4'h2, 32'h0};
    tv[9] = '{1'b0, 12'h010, 32'h0,        4'h0, 32'hDEADBEEF};

    arst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      cke[k] = 1'b1; avalid[k] = 1'b0; addr[k] = '0; wdata[k] = '0; wstrb[k] = '0;
    end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check("rst_ready", 32'(ready[k]), 32'd0);
      check("rst_rvalid", 32'(rvalid[k]), 32'd0);
      check("rst_rdata", rdata[k], 32'd0);
      check("rst_err", 32'(err[k]), 32'd0);
    end
    arst_n = 1'b1;
    #1;
    check("ready_before_edge", 32'(ready[0]), 32'd0);
    tick();
    for (int k = 0; k < NI; k++) check("ready_after_release", 32'(ready[k]), 32'd1);

    // Instance 0: back-to-back table, ready must never drop.
    for (int i = 0; i < NV; i++) begin
      drive(0, tv[i].addr, tv[i].wdata, tv[i].wr ? tv[i].wstrb : 4'h0);
      if (!tv[i].wr) sb_q.push_back('{tv[i].exp, cyc + 1});
      tick();
      check("w0_ready_held", 32'(ready[0]), 32'd1);
    end
    avalid[0] = 1'b0;
    repeat (2) tick();
    check("w0_rvalid_idle", 32'(rvalid[0]), 32'd0);
    check("w0_rdata_hold", rdata[0], 32'hDEADBEEF);
    check("w0_err_inrange", 32'(err[0]), 32'd0);

`ifdef IOB_MEM_RESPONDER_BOUNDS_EN
    // Index 1000 with DEPTH=1000 is out of range: reads zero and sets err.
    drive(0, 12'hFA0, 32'h0, 4'h0);
    sb_q.push_back('{32'h0, cyc + 1});
    tick();
    avalid[0] = 1'b0;
    check("oor_err_set", 32'(err[0]), 32'd1);
    tick();
    drive(0, 12'h010, 32'h0, 4'h0);
    sb_q.push_back('{32'hDEADBEEF, cyc + 1});
    tick();
    avalid[0] = 1'b0;
    repeat (2) tick();
    check("oor_err_sticky", 32'(err[0]), 32'd1);
`else
    drive(0, 12'h020, 32'h0, 4'h0);
    sb_q.push_back('{32'h11BB33DD, cyc + 1});
    tick();
    avalid[0] = 1'b0;
    repeat (2) tick();
    check("err_tied_low", 32'(err[0]), 32'd0);
`endif

    // Instance 1 (WAIT_CYCLES=3): write, then a read with avalid held across WAIT.
    drive(1, 12'h040, 32'h5555AAAA, 4'hF);
    tick();
    avalid[1] = 1'b0;
    check("w3_wr_busy", 32'(ready[1]), 32'd0);
    wait_ready(1);
    check("w3_wr_no_rvalid", 32'(rv_cnt[1]), 32'd0);
    drive(1, 12'h040, 32'h0, 4'h0);
    tick();
    for (int j = 1; j <= 3; j++) begin
      check("w3_wait_ready_low", 32'(ready[1]), 32'd0);
      check("w3_wait_no_rvalid", 32'(rvalid[1]), 32'd0);
      tick();
    end
    check("w3_ready_back", 32'(ready[1]), 32'd1);
    check("w3_rvalid", 32'(rvalid[1]), 32'd1);
    check("w3_rdata", rdata[1], 32'h5555AAAA);
    tick();
    avalid[1] = 1'b0;
    check("w3_second_accepted", 32'(ready[1]), 32'd0);
    check("w3_rvalid_single", 32'(rvalid[1]), 32'd0);
    repeat (2) tick();
    check("w3_second_early", 32'(rvalid[1]), 32'd0);
    tick();
    check("w3_second_rvalid", 32'(rvalid[1]), 32'd1);
    check("w3_second_rdata", rdata[1], 32'h5555AAAA);

    // Reset asserted while a read is waiting: no rvalid, ready back after one edge.
    drive(1, 12'h040, 32'h0, 4'h0);
    tick();
    avalid[1] = 1'b0;
    tick();
    n0 = rv_cnt[1];
    arst_n = 1'b0;
    tick();
    arst_n = 1'b1;
    check("rst_mid_ready_low", 32'(ready[1]), 32'd0);
    tick();
    check("rst_mid_ready_back", 32'(ready[1]), 32'd1);
    repeat (5) tick();
    check("rst_mid_no_rvalid", 32'(rv_cnt[1]), 32'(n0));

    // Memory survives reset.
    drive(1, 12'h040, 32'h0, 4'h0);
    tick();
    avalid[1] = 1'b0;
    repeat (3) tick();
    check("w3_mem_kept_rvalid", 32'(rvalid[1]), 32'd1);
    check("w3_mem_kept_rdata", rdata[1], 32'h5555AAAA);

    // Instance 2 (WAIT_CYCLES=2): two-cycle cke stall during WAIT delays rvalid by two.
    drive(2, 12'h080, 32'h13579BDF, 4'hF);
    tick();
    avalid[2] = 1'b0;
    wait_ready(2);
    drive(2, 12'h080, 32'h0, 4'h0);
    tick();
    avalid[2] = 1'b0;
    cke[2] = 1'b0;
    tick();
    check("cke_stall_1", 32'(rvalid[2]), 32'd0);
    tick();
    check("cke_stall_2", 32'(rvalid[2]), 32'd0);
    cke[2] = 1'b1;
    tick();
    check("cke_undelayed_slot", 32'(rvalid[2]), 32'd0);
    tick();
    check("cke_delayed_rvalid", 32'(rvalid[2]), 32'd1);
    check("cke_delayed_rdata", rdata[2], 32'h13579BDF);
    tick();
    check("cke_rvalid_pulse", 32'(rvalid[2]), 32'd0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
